// File: rtl/graphics_test_top_if.sv
// graphics_test_top_if: raster position, framebuffer address and VGA pins of
// the graphics test top. The master side is driven by graphics_test_top; the
// slave side is for whatever consumes the raster (board pins, fetch path).
interface graphics_test_top_if;
    logic       VGA_HS;
    logic       VGA_VS;
    logic [3:0] VGA_R;
    logic [3:0] VGA_G;
    logic [3:0] VGA_B;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [14:0] pixel_addr;

    modport master (
        output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B,
        output pixel_x, pixel_y, pixel_addr
    );

    modport slave (
        input VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B,
        input pixel_x, pixel_y, pixel_addr
    );
endinterface

// File: rtl/graphics_test_top.sv
// graphics_test_top: board-level VGA test top, 640x480@60 Hz from the 50 MHz
// board clock. A 25 MHz pixel enable steps the raster counters; sync, colour
// and framebuffer address are combinational decodes of those counters.
// Keys[0] is an asynchronous active-high reset, Keys[1] selects the pattern
// (colour bars or checkerboard) at frame boundaries only.
// Optional build macro: BORDER_EN -- forces a one-pixel red border on the
// outermost visible rows and columns.
module graphics_test_top #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int FB_SHIFT  = 2,
    parameter int FB_WIDTH  = 160
) (
    input  logic                 MAX10_CLK1_50,
    input  logic [1:0]           Keys,
    graphics_test_top_if.master  vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] H_EDGE   = 10'(H_VISIBLE - 1);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] V_EDGE   = 10'(V_VISIBLE - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    typedef logic [11:0] rgb_t;  // {R,G,B} nibbles

    typedef enum logic {
        PAT_BARS    = 1'b0,
        PAT_CHECKER = 1'b1
    } pattern_e;

    logic clk;
    logic rst;
    assign clk = MAX10_CLK1_50;
    assign rst = Keys[0];

    logic     pix_en;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic     key_meta;
    logic     key_sync;
    pattern_e pat_sel;

    // Pixel enable: divide the 50 MHz clock down to a 25 MHz strobe.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pix_en <= 1'b0;
        else     pix_en <= ~pix_en;
    end

    // Raster counters: column wraps 799->0 and carries into the line counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_x <= '0;
            pixel_y <= '0;
        end else if (pix_en) begin
            if (pixel_x == H_LAST) begin
                pixel_x <= '0;
                pixel_y <= (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
            end else begin
                pixel_x <= pixel_x + 10'd1;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous pattern-select key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta <= 1'b0;
            key_sync <= 1'b0;
        end else begin
            key_meta <= Keys[1];
            key_sync <= key_meta;
        end
    end

    // Pattern select only updates on the first pixel of a frame, never mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        pat_sel <= PAT_BARS;
        else if (pix_en && pixel_x == '0 && pixel_y == '0) pat_sel <= pattern_e'(key_sync);
    end

    logic       visible;
    logic [2:0] bar_idx;
    rgb_t       bar_rgb;
    rgb_t       checker_rgb;
    rgb_t       rgb;
    logic [14:0] addr_row;
    logic [14:0] addr_col;
    logic [14:0] pixel_addr;

    assign visible     = (pixel_x < H_VIS) && (pixel_y < V_VIS);
    assign bar_idx     = 3'(pixel_x / 10'd80);
    assign checker_rgb = {12{pixel_x[5] ^ pixel_y[5]}};
    assign addr_row    = 15'(pixel_y >> FB_SHIFT) * 15'(FB_WIDTH);
    assign addr_col    = 15'(pixel_x >> FB_SHIFT);

    // Colour-bar lookup: eight 80-pixel bars from white down to black.
    always_comb begin
        unique case (bar_idx)
            3'd0:    bar_rgb = 12'hFFF;
            3'd1:    bar_rgb = 12'hFF0;
            3'd2:    bar_rgb = 12'h0FF;
            3'd3:    bar_rgb = 12'h0F0;
            3'd4:    bar_rgb = 12'hF0F;
            3'd5:    bar_rgb = 12'hF00;
            3'd6:    bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
    end

    // Pixel decode: blank and address zero outside the visible area or in reset.
    // NOTE: defaults are assigned first so no path through this block holds a
    // value, which would otherwise infer a latch.
    always_comb begin
        rgb        = '0;
        pixel_addr = '0;
        if (visible) begin
            pixel_addr = addr_row + addr_col;
            // The counters already sit at (0,0) in reset, which is visible; gate
            // colour so the outputs stay dark while Keys[0] is held.
            if (!rst) begin
                rgb = (pat_sel == PAT_CHECKER) ? checker_rgb : bar_rgb;
`ifdef BORDER_EN
                if (pixel_x == '0 || pixel_x == H_EDGE || pixel_y == '0 || pixel_y == V_EDGE)
                    rgb = 12'hF00;
`else
                // Pattern runs unmodified to the edges in this build.
`endif
            end
        end
    end

    assign vga.VGA_HS     = ~((pixel_x >= HS_START) && (pixel_x <= HS_END));
    assign vga.VGA_VS     = ~((pixel_y >= VS_START) && (pixel_y <= VS_END));
    assign vga.VGA_R      = rgb[11:8];
    assign vga.VGA_G      = rgb[7:4];
    assign vga.VGA_B      = rgb[3:0];
    assign vga.pixel_x    = pixel_x;
    assign vga.pixel_y    = pixel_y;
    assign vga.pixel_addr = pixel_addr;

`ifndef BORDER_EN
    // Edge constants are only consulted by the border build.
    logic unused_edge;
    assign unused_edge = ^{H_EDGE, V_EDGE};
`endif

endmodule

// File: tb/tb_graphics_test_top.sv
// tb_graphics_test_top: scoreboard bench for graphics_test_top. dut_a runs the
// full 640x480 timing; dut_b runs a shrunken raster (64x40 visible) so whole
// frames, vertical sync and frame-boundary pattern switching fit in a short run.
// Directed vectors (coordinate + hand-computed outputs) are queued per DUT and
// a monitor compares them when the raster reaches each coordinate.
module tb_graphics_test_top;

    logic       clk = 1'b0;
    logic [1:0] keys_a;
    logic [1:0] keys_b;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    graphics_test_top_if vif_a ();
    graphics_test_top_if vif_b ();

    graphics_test_top dut_a (
        .MAX10_CLK1_50 (clk),
        .Keys          (keys_a),
        .vga           (vif_a)
    );

    graphics_test_top #(
        .H_VISIBLE (64), .H_FRONT (4), .H_SYNC (8), .H_BACK (4),
        .V_VISIBLE (40), .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
    ) dut_b (
        .MAX10_CLK1_50 (clk),
        .Keys          (keys_b),
        .vga           (vif_b)
    );

    typedef struct {
        int          x;
        int          y;
        logic [28:0] exp;   // {hs, vs, rgb[11:0], addr[14:0]}
    } vec_t;

    vec_t qa[$];
    vec_t qb[$];

    function automatic logic [28:0] pack(logic hs, logic vs, logic [11:0] rgb, logic [14:0] addr);
        return {hs, vs, rgb, addr};
    endfunction

    // Colour expected on an outermost visible pixel: red in the border build.
    function automatic logic [11:0] edge_rgb(logic [11:0] plain);
`ifdef BORDER_EN
        return 12'hF00;
`else
        return plain;
`endif
    endfunction

    function automatic logic [28:0] sample_a();
        return {vif_a.VGA_HS, vif_a.VGA_VS, vif_a.VGA_R, vif_a.VGA_G, vif_a.VGA_B, vif_a.pixel_addr};
    endfunction

    function automatic logic [28:0] sample_b();
        return {vif_b.VGA_HS, vif_b.VGA_VS, vif_b.VGA_R, vif_b.VGA_G, vif_b.VGA_B, vif_b.pixel_addr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input bit to_b, input int x, input int y, input logic [28:0] exp);
        vec_t v;
        v.x = x; v.y = y; v.exp = exp;
        if (to_b) qb.push_back(v);
        else      qa.push_back(v);
    endtask

    // Wait (bounded) until the chosen DUT's raster reaches (x,y).
    task automatic wait_coord(input bit on_b, input int x, input int y, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (on_b ? (vif_b.pixel_x == 10'(x) && vif_b.pixel_y == 10'(y))
                     : (vif_a.pixel_x == 10'(x) && vif_a.pixel_y == 10'(y))) begin
                ok = 1'b1;
                return;
            end
        end
        n_cmp++;
        n_err++;
        $display("FAIL wait_%s(%0d,%0d): timed out after %0d cycles", on_b ? "b" : "a", x, y, budget);
    endtask

    // Monitors: compare the queue head when its coordinate comes up.
    always @(negedge clk) begin
        if (qa.size() > 0 && vif_a.pixel_x == 10'(qa[0].x) && vif_a.pixel_y == 10'(qa[0].y)) begin
            check($sformatf("a(%0d,%0d)", qa[0].x, qa[0].y), 32'(sample_a()), 32'(qa[0].exp));
            void'(qa.pop_front());
        end
    end

    always @(negedge clk) begin
        if (qb.size() > 0 && vif_b.pixel_x == 10'(qb[0].x) && vif_b.pixel_y == 10'(qb[0].y)) begin
            check($sformatf("b(%0d,%0d)", qb[0].x, qb[0].y), 32'(sample_b()), 32'(qb[0].exp));
            void'(qb.pop_front());
        end
    end

    initial begin
        keys_a = 2'b01;
        keys_b = 2'b01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_a", 32'(sample_a()), 32'(pack(1'b1, 1'b1, 12'h000, 15'd0)));
        check("reset_xy_a", {12'd0, vif_a.pixel_x, vif_a.pixel_y}, 32'd0);
        check("reset_out_b", 32'(sample_b()), 32'(pack(1'b1, 1'b1, 12'h000, 15'd0)));
        check("reset_xy_b", {12'd0, vif_b.pixel_x, vif_b.pixel_y}, 32'd0);

        keys_a[0] = 1'b0;
        keys_b[0] = 1'b0;
        @(posedge clk); #1 check("release_x_1clk", 32'(vif_a.pixel_x), 32'd0);
        @(posedge clk); #1 check("release_x_2clk", 32'(vif_a.pixel_x), 32'd1);
        repeat (2) @(posedge clk);
        #1 check("release_x_4clk", 32'(vif_a.pixel_x), 32'd2);

        // dut_a, full timing, colour bars throughout (key raised mid-frame).
        push(0, 639,  0, pack(1, 1, edge_rgb(12'h000), 15'd159));
        push(0, 640,  0, pack(1, 1, 12'h000, 15'd0));
        push(0, 655,  0, pack(1, 1, 12'h000, 15'd0));
        push(0, 656,  0, pack(0, 1, 12'h000, 15'd0));
        push(0, 751,  0, pack(0, 1, 12'h000, 15'd0));
        push(0, 752,  0, pack(1, 1, 12'h000, 15'd0));
        push(0,   4,  4, pack(1, 1, 12'hFFF, 15'd161));
        push(0,  80, 10, pack(1, 1, 12'hFF0, 15'd340));
        push(0,   0, 12, pack(1, 1, edge_rgb(12'hFFF), 15'd480));
        push(0, 160, 12, pack(1, 1, 12'h0FF, 15'd520));
        push(0, 240, 12, pack(1, 1, 12'h0F0, 15'd540));
        push(0, 320, 12, pack(1, 1, 12'hF0F, 15'd560));
        push(0, 400, 12, pack(1, 1, 12'hF00, 15'd580));
        push(0, 480, 12, pack(1, 1, 12'h00F, 15'd600));
        push(0, 639, 12, pack(1, 1, edge_rgb(12'h000), 15'd639));
        push(0,  32, 32, pack(1, 1, 12'hFFF, 15'd1288));

        // dut_b, 80x47 raster: frame 0 bars, frame 1 checkerboard.
        push(1,  40, 33, pack(1, 1, 12'hFFF, 15'd1290));
        push(1,   0, 41, pack(1, 1, 12'h000, 15'd0));
        push(1,   0, 42, pack(1, 0, 12'h000, 15'd0));
        push(1,   0, 43, pack(1, 0, 12'h000, 15'd0));
        push(1,   0, 44, pack(1, 1, 12'h000, 15'd0));
        push(1,  67, 45, pack(1, 1, 12'h000, 15'd0));
        push(1,  68, 45, pack(0, 1, 12'h000, 15'd0));
        push(1,  75, 45, pack(0, 1, 12'h000, 15'd0));
        push(1,  76, 45, pack(1, 1, 12'h000, 15'd0));
        push(1,  32,  0, pack(1, 1, edge_rgb(12'hFFF), 15'd8));
        push(1,  64,  0, pack(1, 1, 12'h000, 15'd0));
        push(1,  32, 32, pack(1, 1, 12'h000, 15'd1288));
        push(1,  63, 39, pack(1, 1, edge_rgb(12'h000), 15'd1455));

        fork
            begin : key_a_thread
                bit ok;
                wait_coord(0, 0, 11, 30000, ok);
                keys_a[1] = 1'b1;
            end
            begin : key_b_thread
                bit ok;
                wait_coord(1, 0, 5, 3000, ok);
                keys_b[1] = 1'b1;
            end
            begin : line_period
                bit ok1, ok2;
                int t0;
                wait_coord(0, 0, 1, 4000, ok1);
                t0 = cyc;
                wait_coord(0, 0, 2, 4000, ok2);
                if (ok1 && ok2) check("line_period", 32'(cyc - t0), 32'd1600);
            end
            begin : frame_period
                bit ok1, ok2, ok3;
                int t0;
                wait_coord(1, 0, 1, 2000, ok1);
                t0 = cyc;
                wait_coord(1, 0, 2, 2000, ok2);
                wait_coord(1, 0, 1, 10000, ok3);
                if (ok1 && ok2 && ok3) check("frame_period_b", 32'(cyc - t0), 32'd7520);
            end
        join

        for (int i = 0; i < 60000 && (qa.size() > 0 || qb.size() > 0); i++) @(posedge clk);
        while (qa.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL a(%0d,%0d): never reached, expected %h", qa[0].x, qa[0].y, qa[0].exp);
            void'(qa.pop_front());
        end
        while (qb.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL b(%0d,%0d): never reached, expected %h", qb[0].x, qb[0].y, qb[0].exp);
            void'(qb.pop_front());
        end

        // Mid-frame reset: outputs must clear without waiting for a clock edge.
        repeat (3) @(negedge clk);
        #3 keys_a[0] = 1'b1;
        #1;
        check("midreset_out", 32'(sample_a()), 32'(pack(1'b1, 1'b1, 12'h000, 15'd0)));
        check("midreset_xy", {12'd0, vif_a.pixel_x, vif_a.pixel_y}, 32'd0);
        @(negedge clk);
        keys_a[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("midreset_restart", {12'd0, vif_a.pixel_x, vif_a.pixel_y}, {12'd0, 10'd1, 10'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
